// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: single-clock 1RW+1R SRAM model with registered outputs, hardware
// zero-init after reset and a same-address collision strobe. Option macro: SRAM_BYPASS_EN.
module sram_1rw1r_param #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int WMASK_WIDTH = DATA_WIDTH / 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   csb0,
   input  logic                   web0,
   input  logic [WMASK_WIDTH-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0]  din0,
   output logic [DATA_WIDTH-1:0]  dout0,
   output logic                   dout0_vld,
   input  logic                   csb1,
   input  logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  dout1,
   output logic                   dout1_vld,
   output logic                   init_busy,
   output logic                   collision
);
   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int LW        = DATA_WIDTH / WMASK_WIDTH;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] init_cnt_r;
   logic [ADDR_WIDTH-1:0] init_cnt_nxt_s;
   logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

   logic                  init_wr_s;
   logic                  wr0_en_s;
   logic                  rd0_en_s;
   logic                  rd1_en_s;
   logic                  collision_s;
   logic [DATA_WIDTH-1:0] wr_word_s;
   logic [DATA_WIDTH-1:0] rd1_word_s;

   logic [DATA_WIDTH-1:0] dout0_r;
   logic [DATA_WIDTH-1:0] dout1_r;
   logic                  dout0_vld_r;
   logic                  dout1_vld_r;
   logic                  init_busy_r;
   logic                  collision_r;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0]  old_word,
      input logic [DATA_WIDTH-1:0]  new_word,
      input logic [WMASK_WIDTH-1:0] mask
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < WMASK_WIDTH; i++) begin
         if (mask[i]) begin
            res[i*LW +: LW] = new_word[i*LW +: LW];
         end else begin
            res[i*LW +: LW] = old_word[i*LW +: LW];
         end
      end
      return res;
   endfunction

   // FSM state and init address register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_INIT;
         init_cnt_r <= '0;
      end else begin
         state_r    <= state_nxt_s;
         init_cnt_r <= init_cnt_nxt_s;
      end
   end

   // FSM next state: INIT sweeps every address once, then RUN until the next reset
   always_comb begin
      state_nxt_s    = state_r;
      init_cnt_nxt_s = init_cnt_r;
      case (state_r)
         ST_INIT: begin
            init_cnt_nxt_s = init_cnt_r + ADDR_WIDTH'(1);
            if (&init_cnt_r) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_RUN: begin
            state_nxt_s = ST_RUN;
         end
         default: begin
            state_nxt_s    = ST_INIT;
            init_cnt_nxt_s = '0;
         end
      endcase
   end

   // Request decode; all requests are dropped while reset is held or INIT runs
   always_comb begin
      init_wr_s   = rst_n && (state_r == ST_INIT);
      wr0_en_s    = rst_n && (state_r == ST_RUN) && !csb0 && !web0;
      rd0_en_s    = rst_n && (state_r == ST_RUN) && !csb0 && web0;
      rd1_en_s    = rst_n && (state_r == ST_RUN) && !csb1;
      collision_s = wr0_en_s && !csb1 && (addr0 == addr1);
      wr_word_s   = merge_lanes(mem_r[addr0], din0, wmask0);
`ifdef SRAM_BYPASS_EN
      // addr0 == addr1 on collision, so the merged write word is the forwarded value
      if (collision_s) begin
         rd1_word_s = wr_word_s;
      end else begin
         rd1_word_s = mem_r[addr1];
      end
`else
      rd1_word_s = mem_r[addr1];
`endif
   end

   // Storage array: zero fill during INIT, masked port-0 write in RUN
   always_ff @(posedge clk) begin
      if (init_wr_s) begin
         mem_r[init_cnt_r] <= '0;
      end else if (wr0_en_s) begin
         mem_r[addr0] <= wr_word_s;
      end
   end

   // Output registers: data holds unless its port reads, strobes last one cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout0_r     <= '0;
         dout1_r     <= '0;
         dout0_vld_r <= 1'b0;
         dout1_vld_r <= 1'b0;
         collision_r <= 1'b0;
         init_busy_r <= 1'b1;
      end else begin
         if (rd0_en_s) begin
            dout0_r <= mem_r[addr0];
         end
         if (rd1_en_s) begin
            dout1_r <= rd1_word_s;
         end
         dout0_vld_r <= rd0_en_s;
         dout1_vld_r <= rd1_en_s;
         collision_r <= collision_s;
         init_busy_r <= (state_nxt_s == ST_INIT);
      end
   end

   assign dout0     = dout0_r;
   assign dout1     = dout1_r;
   assign dout0_vld = dout0_vld_r;
   assign dout1_vld = dout1_vld_r;
   assign collision = collision_r;
   assign init_busy = init_busy_r;
endmodule
